// File: rtl/instr_pkg.sv
// Shared definitions for the instruction fetch unit: control-field
// encodings, FSM state type and instruction-word field offsets.
package instr_pkg;

  // Control field encodings (top two bits of every instruction word)
  localparam logic [1:0] CTRL_ALU  = 2'b00;
  localparam logic [1:0] CTRL_JMP  = 2'b01;
  localparam logic [1:0] CTRL_HALT = 2'b10;
  localparam logic [1:0] CTRL_NOP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    HALT
  } state_t;

  // Word layout, MSB to LSB: ctrl[1:0], alu_sel, a, b. Operand b sits at bit 0.
  function automatic int a_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int sel_lsb(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int ctrl_lsb(input int sel_w, input int data_w);
    return 2 * data_w + sel_w;
  endfunction

endpackage

// File: rtl/instr_rom_mem.sv
// Program store: DEPTH x IW array, one write port, one registered read port.
// Contents are never cleared, so a program survives reset.
module instr_rom_mem #(
  parameter int DEPTH  = 16,
  parameter int IW     = 21,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [IW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [IW-1:0]     rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; data for the address presented in FETCH is valid in DECODE
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/decode/issue controller feeding a downstream ALU.
// Build option: INSTR_FETCH_LOOP_EN -- when defined, pc wraps from DEPTH-1
// to 0 after an accepted issue and execution continues; otherwise the unit
// halts after accepting the issue at DEPTH-1.
//
// state  | meaning
// IDLE   | waiting for start, program may be loaded
// FETCH  | pc presented to program memory
// DECODE | memory word valid, act on ctrl field
// ISSUE  | ALU instruction on outputs, waiting for out_ready
// HALT   | stopped, program may be loaded, start restarts at pc 0
module instr_fetch_unit
  import instr_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int SEL_W  = 3,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IW     = 2 + SEL_W + 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [IW-1:0]     prog_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [SEL_W-1:0]  alu_sel_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted
);

  localparam int CTRL_LSB = ctrl_lsb(SEL_W, DATA_W);
  localparam int SEL_LSB  = sel_lsb(DATA_W);
  localparam int A_LSB    = a_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt, pc_inc;
  logic                valid_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic [DATA_W-1:0]   a_nxt, b_nxt;
  logic [IW-1:0]       rd_word;
  logic [1:0]          rd_ctrl;
  logic [SEL_W-1:0]    rd_sel;
  logic [DATA_W-1:0]   rd_a, rd_b;
  logic                mem_we;

  // Loading is only allowed while the unit is not executing
  assign mem_we = prog_we && ((state == IDLE) || (state == HALT));

  instr_rom_mem #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(rd_word)
  );

  assign rd_ctrl = rd_word[CTRL_LSB +: 2];
  assign rd_sel  = rd_word[SEL_LSB +: SEL_W];
  assign rd_a    = rd_word[A_LSB +: DATA_W];
  assign rd_b    = rd_word[0 +: DATA_W];

  // Sequential increment also wraps for non-power-of-two DEPTH
  assign pc_inc = (pc == LAST_PC) ? '0 : pc + 1'b1;

  assign pc_out = pc;
  assign busy   = (state == FETCH) || (state == DECODE) || (state == ISSUE);
  assign halted = (state == HALT);

  // State, pc and issue registers; reset aborts everything including a pending issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      out_valid   <= 1'b0;
      alu_sel_out <= '0;
      a_out       <= '0;
      b_out       <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      out_valid   <= valid_nxt;
      alu_sel_out <= sel_nxt;
      a_out       <= a_nxt;
      b_out       <= b_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    sel_nxt   = alu_sel_out;
    a_nxt     = a_out;
    b_nxt     = b_out;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (rd_ctrl)
          CTRL_ALU: begin
            sel_nxt   = rd_sel;
            a_nxt     = rd_a;
            b_nxt     = rd_b;
            valid_nxt = 1'b1;
            state_nxt = ISSUE;
          end
          CTRL_JMP: begin
            // Targets beyond the program are truncated to the pc width
            pc_nxt    = rd_b[ADDR_W-1:0];
            state_nxt = FETCH;
          end
          CTRL_HALT: state_nxt = HALT;
          default: begin
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        endcase
      end
      ISSUE: begin
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          if (pc == LAST_PC) begin
`ifdef INSTR_FETCH_LOOP_EN
            pc_nxt    = '0;
            state_nxt = FETCH;
`else
            state_nxt = HALT;
`endif
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_W, default 8, operand width.
REQ-002 Parameter SEL_W, default 3, ALU select width.
REQ-003 Parameter DEPTH, default 16, instruction words.
REQ-004 Derived constants:
- ADDR_W = clog2(DEPTH).
- IW = 2 + SEL_W + 2*DATA_W.
- Word layout, MSB to LSB: ctrl[1:0], alu_sel, a, b.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  begin execution from PC 0.
REQ-009 prog_we  in  1  program-write strobe.
REQ-010 prog_addr  in  ADDR_W  write address.
REQ-011 prog_data  in  IW  write word.
REQ-012 out_ready  in  1  downstream ALU accepts the issued instruction.
REQ-013 out_valid  out  1  alu_sel_out, a_out and b_out are valid.
REQ-014 alu_sel_out  out  SEL_W  ALU operation select.
REQ-015 a_out  out  DATA_W  operand A.
REQ-016 b_out  out  DATA_W  operand B.
REQ-017 pc_out  out  ADDR_W  current program counter.
REQ-018 busy  out  1  high in FETCH, DECODE and ISSUE.
REQ-019 halted  out  1  high in HALT.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, DECODE, ISSUE and HALT.
REQ-021 Program memory SHALL use a registered synchronous read, with read data valid one cycle after FETCH.
REQ-022 IDLE with start=1: pc<=0, next state FETCH.
REQ-023 FETCH: present pc to memory; next state DECODE.
REQ-024 DECODE actions by ctrl:
- ctrl=00 (ALU): register the fields to the outputs, set out_valid<=1, go to ISSUE.
- ctrl=01 (JMP): pc<=b[ADDR_W-1:0], go to FETCH, no issue.
- ctrl=10 (HALT): go to HALT.
- ctrl=11 (NOP): pc<=pc+1, go to FETCH.
REQ-025 ISSUE:
- Outputs SHALL hold stable while out_ready=0.
- On out_valid&&out_ready: out_valid<=0, pc<=pc+1, go to FETCH.
REQ-026 Latency: start sampled at edge k SHALL produce out_valid=1 after edge k+2 when word 0 is an ALU word.
REQ-027 Sustained throughput with out_ready held high SHALL be one issue per 3 cycles.
REQ-028 End of program: accepting an issue at pc=DEPTH-1 SHALL follow REQ-038.
REQ-029 HALT: start=1 SHALL set pc<=0 and go to FETCH; otherwise remain in HALT.
REQ-030 prog_we SHALL write memory only in IDLE or HALT and SHALL be ignored in all other states.
REQ-031 prog_we and start in the same IDLE cycle: the write SHALL be visible to the first fetch.
REQ-032 start SHALL be ignored in FETCH, DECODE and ISSUE.
REQ-033 A JMP target of DEPTH or more SHALL be truncated to ADDR_W bits.

Reset
REQ-034 rst=1 at a rising edge SHALL set:
- state=IDLE, pc=0, out_valid=0;
- alu_sel_out, a_out and b_out to 0;
- busy=0, halted=0.
REQ-035 Reset SHALL take priority over all inputs and SHALL abort any state, including ISSUE with out_valid=1.
REQ-036 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-037 The macro INSTR_FETCH_LOOP_EN SHALL select end-of-program behaviour.
REQ-038 With INSTR_FETCH_LOOP_EN defined, pc SHALL wrap from DEPTH-1 to 0 and execution SHALL continue. Without it, the state SHALL go to HALT after an accepted issue at DEPTH-1.

Structure
REQ-039 Package instr_pkg SHALL hold:
- the ctrl encoding constants: CTRL_ALU, CTRL_JMP, CTRL_HALT, CTRL_NOP;
- the FSM state typedef;
- field-offset helper constants.
REQ-040 Sub-module instr_rom_mem SHALL implement the DEPTH x IW array with one write port and one registered read port.

Verification
REQ-041 Reset flow: reset, program word0={00,3'd2,8'h05,8'h03}, start -> out_valid=1 after 3 edges; alu_sel_out=2, a_out=0x05, b_out=0x03, pc_out=0.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles -> outputs and pc stable, out_valid=1 throughout; out_ready=1 -> pc_out=1 next cycle.
REQ-043 Jump: word1={01,x,x,8'h06}, word6 ALU with a=0x11 -> next issue shows a_out=0x11, pc_out=6.
REQ-044 Halt and protect:
- word2=HALT -> halted=1.
- prog_we while busy -> memory unchanged.
- start from HALT -> restart at pc 0.
REQ-045 End of program: DEPTH=4, all words ALU -> with the macro, fifth issue at pc 0; without it, halted=1 after the fourth issue.
REQ-046 Reset mid-issue: assert rst while in ISSUE -> out_valid=0, pc_out=0, state IDLE next cycle.
